credit_rx_buffer: RTL and testbench
===================================

# credit_rx_buffer

Receiver end of the credit-based flow-control link used between MSM pipeline stages. The upstream transmitter holds a credit counter preset to `C_DEPTH` and sends one word per credit. This block stores arriving words in a first-word-fall-through FIFO and returns freed slots to the transmitter as coalesced credit pulses. Partial batches are flushed on an idle timeout, so credits are never stranded.

## Interface
Parameters:
- `C_DATA_W`, 64, payload width.
- `C_DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `C_CRED_W`, `$clog2(C_DEPTH+1)`, width of the credit-count and level fields.
- `C_BATCH`, 4, number of credits coalesced before a return; 1 ≤ `C_BATCH` ≤ `C_DEPTH`.
- `C_FLUSH_CYC`, 8, pop-free cycles after which a partial batch is returned; ≥ 1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  word arrives. There is no ready signal; the credit guarantees space.
- `in_data_i`  in  `C_DATA_W`  arriving word.
- `out_valid_o`  out  1  head-of-FIFO word is valid.
- `out_data_o`  out  `C_DATA_W`  head word.
- `out_ready_i`  in  1  consumer accepts the head word.
- `cred_valid_o`  out  1  one-cycle credit-return pulse.
- `cred_count_o`  out  `C_CRED_W`  credits returned with the pulse; zero when not pulsing.
- `level_o`  out  `C_CRED_W`  current FIFO occupancy.
- `overflow_o`  out  1  sticky error: a word arrived while the FIFO was full.

## Operation
- push = `in_valid_i`. pop = `out_valid_o && out_ready_i`.
- **Push when level == `C_DEPTH`:**
  - Applies regardless of a simultaneous pop.
  - The word is dropped and the level is not incremented by the push.
  - `overflow_o` is set and stays set until `rst`.
- **Level update:** `level_o` next = level + accepted push − pop. A simultaneous push and pop leaves the level unchanged; FIFO order is preserved.
- **Credit accumulator:** registers `pend_r` (width `C_CRED_W`) and `idle_r` (width `$clog2(C_FLUSH_CYC)+1`).
- **States:**
  - IDLE: `pend_r` == 0.
  - ACCUM: `pend_r` > 0.
- **Per-edge rule, with p = `pend_r` + pop:**
  - **Batch return.** If p ≥ `C_BATCH`: `cred_valid_o`←1, `cred_count_o`←p, `pend_r`←0, `idle_r`←0. Next state is IDLE.
  - **Flush return.** Else if `pend_r` > 0, no pop, and `idle_r` == `C_FLUSH_CYC`−1: `cred_valid_o`←1, `cred_count_o`←`pend_r`, `pend_r`←0, `idle_r`←0. Next state is IDLE.
  - **Otherwise.**
    - `cred_valid_o`←0, `cred_count_o`←0, `pend_r`←p.
    - `idle_r`←0 on a pop, or when p == 0.
    - Else `idle_r` increments.
- A pop in the cycle a pulse is being driven is counted into the new `pend_r`; no credit is lost.
- **Invariant:** `level_o` + `pend_r` + in-flight credits + transmitter counter == `C_DEPTH`.
- **No initial grant.** No credit pulse is issued after reset. The transmitter presets its counter to `C_DEPTH`.
- **Reset mid-operation:**
  - FIFO is emptied; `pend_r` and `idle_r` are cleared; `overflow_o` is cleared.
  - Unreturned credits are discarded. The transmitter must be reset in the same cycle.

## Timing
- **Reset values:** `out_valid_o`=0, `out_data_o`=0, `cred_valid_o`=0, `cred_count_o`=0, `level_o`=0, `overflow_o`=0.
- **Push → `out_valid_o`:** 1 cycle. A word written at edge N is visible in cycle N+1, with FWFT behaviour.
- **Pop → next head word:** visible in the following cycle.
- **Pop → credit pulse:** the pulse appears in the cycle after the triggering pop, which is the pop that brings p to `C_BATCH`.
- **Last pop (cycle t) with no further pops:** the flush pulse appears in cycle t + `C_FLUSH_CYC` + 1.
- **`overflow_o`:** asserted from the cycle after the offending push.
- **`level_o`:** registered; reflects all pushes and pops up to the previous edge.

## Structure
- Package `credit_pkg` holds:
  - the function `cred_w(depth)` = `$clog2(depth+1)`;
  - the state enum `cred_state_e` {IDLE, ACCUM};
  - the typedef `cred_t` for credit-count fields, shared with the transmitter side.
- Sub-module `fifo_sync_fwft`: storage, pointers, level, and FWFT output register. The top level adds overflow detection, the credit accumulator, the flush timer, and the return logic.

## Test plan
Configuration for all scenarios: `C_DEPTH`=16, `C_BATCH`=4, `C_FLUSH_CYC`=8.
- **Fill:** push 0..15 on consecutive cycles with `out_ready_i`=0. Expect `out_valid_o`=1 one cycle after the first push, `out_data_o`=0, `level_o`=16, no credit pulse, `overflow_o`=0.
- **Drain:** then hold `out_ready_i`=1 for 16 cycles. Expect data 0..15 in order. Expect four pulses with count 4, each one cycle after pops 4, 8, 12 and 16. Total returned = 16, and `level_o`=0.
- **Flush:** push 3 words, pop 3, then idle. Expect exactly one pulse with count 3 in cycle t+9, where t is the last pop cycle, and no earlier pulse.
- **Overflow:** at `level_o`=16, push 0xDEAD with a simultaneous pop. Expect `overflow_o`=1 from the next cycle and sticky; `level_o`=15; 0xDEAD is never output.
- **Simultaneous push/pop:** at `level_o`=5, push and pop for 10 cycles. Expect `level_o` to stay 5, order to be preserved, and a pulse of count 4 on every fourth pop.
- **Mid-operation reset:** with `pend_r`=2 and `level_o`=7, assert `rst` for 1 cycle. Expect all outputs at their reset values the next cycle, and no credit pulse for the discarded entries.

Source files
------------

// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared credit-link types and sizing helper
package credit_pkg;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CRED_DEPTH_DEFAULT = 16;
  localparam int CRED_W_DEFAULT     = cred_w(CRED_DEPTH_DEFAULT);

  typedef enum logic {IDLE, ACCUM} cred_state_e;

  typedef logic [CRED_W_DEFAULT-1:0] cred_t;

endpackage

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - synchronous first-word-fall-through FIFO
module fifo_sync_fwft #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wr_acc;
  logic              rd_acc;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign rd_valid_o = (level_q != '0);
  assign level_o    = level_q;
  // Empty slots read as zero so the head port never shows stale storage.
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && rd_valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - credit-flow receiver: FWFT buffer plus coalesced credit return
module credit_rx_buffer
  import credit_pkg::*;
#(
  parameter int C_DATA_W    = 64,
  parameter int C_DEPTH     = 16,
  parameter int C_CRED_W    = cred_w(C_DEPTH),
  parameter int C_BATCH     = 4,
  parameter int C_FLUSH_CYC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [C_DATA_W-1:0] in_data_i,
  output logic                out_valid_o,
  output logic [C_DATA_W-1:0] out_data_o,
  input  logic                out_ready_i,
  output logic                cred_valid_o,
  output logic [C_CRED_W-1:0] cred_count_o,
  output logic [C_CRED_W-1:0] level_o,
  output logic                overflow_o
);

  localparam int IDLE_W = $clog2(C_FLUSH_CYC) + 1;

  logic                full;
  logic                pop;
  logic [C_CRED_W-1:0] p;

  cred_state_e         state_q, state_d;
  logic [C_CRED_W-1:0] pend_q, pend_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                cred_valid_q, cred_valid_d;
  logic [C_CRED_W-1:0] cred_count_q, cred_count_d;
  logic                overflow_q, overflow_d;

  fifo_sync_fwft #(
    .DATA_W (C_DATA_W),
    .DEPTH  (C_DEPTH),
    .LVL_W  (C_CRED_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (in_valid_i),
    .wr_data_i  (in_data_i),
    .rd_en_i    (out_ready_i),
    .rd_valid_o (out_valid_o),
    .rd_data_o  (out_data_o),
    .level_o    (level_o),
    .full_o     (full)
  );

  assign pop = out_valid_o && out_ready_i;
  assign p   = pend_q + C_CRED_W'(pop);

  assign cred_valid_o = cred_valid_q;
  assign cred_count_o = cred_count_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = p;
    idle_d       = idle_q;
    cred_valid_d = 1'b0;
    cred_count_d = '0;
    overflow_d   = overflow_q | (in_valid_i && full);

    if (p >= C_CRED_W'(C_BATCH)) begin
      cred_valid_d = 1'b1;
      cred_count_d = p;
      pend_d       = '0;
      idle_d       = '0;
    end else if (state_q == ACCUM && !pop && idle_q == IDLE_W'(C_FLUSH_CYC - 1)) begin
      // Idle timeout: hand back the partial batch so no credit is stranded.
      cred_valid_d = 1'b1;
      cred_count_d = pend_q;
      pend_d       = '0;
      idle_d       = '0;
    end else if (pop || p == '0) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end

    state_d = (pend_d != '0) ? ACCUM : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      idle_q       <= '0;
      cred_valid_q <= 1'b0;
      cred_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      idle_q       <= idle_d;
      cred_valid_q <= cred_valid_d;
      cred_count_q <= cred_count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - directed self-checking bench for credit_rx_buffer
module tb_credit_rx_buffer;

  localparam int DW = 64;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready_i;
  logic          cred_valid_o;
  logic [CW-1:0] cred_count_o;
  logic [CW-1:0] level_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  credit_rx_buffer #(
    .C_DATA_W    (DW),
    .C_DEPTH     (16),
    .C_CRED_W    (CW),
    .C_BATCH     (4),
    .C_FLUSH_CYC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .cred_valid_o (cred_valid_o),
    .cred_count_o (cred_count_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_out_data"}, out_data_o, 64'd0);
    check({tag, "_cred_valid"}, 64'(cred_valid_o), 64'd0);
    check({tag, "_cred_count"}, 64'(cred_count_o), 64'd0);
    check({tag, "_level"}, 64'(level_o), 64'd0);
    check({tag, "_overflow"}, 64'(overflow_o), 64'd0);
  endtask

  initial begin
    int sum;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Fill 0..15 with the consumer stalled.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      if (i == 0) check("fill_valid_before", 64'(out_valid_o), 64'd0);
      if (i == 1) begin
        check("fill_valid_after1", 64'(out_valid_o), 64'd1);
        check("fill_head", out_data_o, 64'd0);
      end
      check("fill_no_cred", 64'(cred_valid_o), 64'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("fill_level", 64'(level_o), 64'd16);
    check("fill_overflow", 64'(overflow_o), 64'd0);
    check("fill_head_final", out_data_o, 64'd0);

    // Drain: pulses of 4 in the cycle after pops 4, 8, 12, 16.
    sum = 0;
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, '0, k < 16);
      if (k < 16) begin
        check("drain_valid", 64'(out_valid_o), 64'd1);
        check("drain_data", out_data_o, 64'(k));
      end
      check("drain_cred_valid", 64'(cred_valid_o), (k == 4 || k == 8 || k == 12 || k == 16) ? 64'd1 : 64'd0);
      check("drain_cred_count", 64'(cred_count_o), (k == 4 || k == 8 || k == 12 || k == 16) ? 64'd4 : 64'd0);
      if (cred_valid_o) sum += int'(cred_count_o);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("drain_total", 64'(sum), 64'd16);
    check("drain_level", 64'(level_o), 64'd0);

    // Flush: 3 words in, 3 out, then idle; pulse lands 9 cycles after the last pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(100 + i), 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      check("flush_data", out_data_o, 64'(100 + i));
      check("flush_no_early", 64'(cred_valid_o), 64'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      check("flush_cred_valid", 64'(cred_valid_o), (j == 9) ? 64'd1 : 64'd0);
      check("flush_cred_count", 64'(cred_count_o), (j == 9) ? 64'd3 : 64'd0);
      tick();
    end

    // Overflow: push while full with a simultaneous pop; the word is dropped.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(16'h100 + i), 1'b0);
      tick();
    end
    check("ovf_level_full", 64'(level_o), 64'd16);
    drive(1'b1, 64'hDEAD, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_level", 64'(level_o), 64'd15);
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, '0, 1'b1);
      check("ovf_drain_data", out_data_o, 64'(16'h101 + k));
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("ovf_empty", 64'(out_valid_o), 64'd0);
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    tick();
    tick();
    tick();

    // Simultaneous push/pop at level 5.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(16'h200 + i), 1'b0);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, DW'(16'h205 + k), 1'b1);
      check("sim_level", 64'(level_o), 64'd5);
      check("sim_data", out_data_o, 64'(16'h200 + k));
      check("sim_cred_valid", 64'(cred_valid_o), (k == 4 || k == 8) ? 64'd1 : 64'd0);
      check("sim_cred_count", 64'(cred_count_o), (k == 4 || k == 8) ? 64'd4 : 64'd0);
      tick();
    end

    // Two more pushes: level 7 with two credits pending, then reset.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DW'(16'h20F + i), 1'b0);
      check("pre_rst_no_cred", 64'(cred_valid_o), 64'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("pre_rst_level", 64'(level_o), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    for (int j = 0; j < 12; j++) begin
      check("post_rst_no_cred", 64'(cred_valid_o), 64'd0);
      check("post_rst_level", 64'(level_o), 64'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
